uart_rx_sampler: RTL and testbench
==================================

// Module: uart_rx_sampler
// PURPOSE
//  - Synthesizable UART receiver with 16x oversampling, majority-vote sampling and FWFT receive FIFO.
//  - Sits on the SoC uart_tx line as its direct consumer, on-chip for loopback or on the bench.
//  - Turns the serial stream into bytes with framing, parity and overrun status.
// PARAMETERS
//  FIFO_DEPTH   8    receive FIFO entries, power of two, >=2
//  DIV_WIDTH    16   width of baud_div
//  OVERSAMPLE   16   ticks per bit, fixed; mid-bit sample at tick 7
//  PARITY_ODD   0    0 = even parity, 1 = odd parity; used only with UART_RX_PARITY_EN
// PORTS
//  clk_in       in   1                   system clock
//  reset        in   1                   asynchronous, active-low reset
//  rx           in   1                   serial input, async to clk_in, idle high
//  rx_en        in   1                   enables start-bit detection
//  baud_div     in   DIV_WIDTH           clk_in cycles per oversample tick; 0 is treated as 1
//  rdata        out  8                   FIFO head byte, valid while rvalid
//  rvalid       out  1                   FIFO not empty
//  rready       in   1                   pop FIFO head when rvalid && rready
//  fifo_level   out  $clog2(FIFO_DEPTH)+1  bytes held in FIFO
//  framing_err  out  1                   sticky: stop bit sampled 0
//  parity_err   out  1                   sticky: parity mismatch
//  overrun      out  1                   sticky: byte dropped because FIFO was full
//  err_clr      in   1                   synchronous clear of all three sticky flags
// BEHAVIOUR
//  - Reset (reset=0): rx synchronizer flops =1, FSM=IDLE, counters=0, FIFO empty.
//    Outputs: rdata=0, rvalid=0, fifo_level=0, all error flags=0.
//  - rx passes through a 2-flop synchronizer, then a 3-deep shift register clocked on tick.
//    The sampled bit is the majority of the last 3 ticks.
//  - Tick generator: down-counter reloads with max(baud_div,1)-1 and pulses tick for 1 clk at 0.
//    It is held in reload while FSM=IDLE.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE: synced rx=0 with rx_en=1 -> START; tick counter and oversample counter (4b) cleared.
//  - START: at oversample count 7, voted bit=1 -> false start, return to IDLE; else -> DATA.
//  - DATA: 8 bits, LSB first, each sampled at count 7 of its bit period; after bit 7 -> PARITY or STOP.
//  - PARITY: sample at count 7; compare with XOR of data ^ PARITY_ODD.
//  - STOP: sample at count 7; FSM returns to IDLE on that same clk, so back-to-back frames are not lost.
//      stop=0 -> framing_err<=1, byte discarded.
//      stop=1 and no parity error -> byte pushed.
//  - Push latency: byte at rdata with rvalid=1 on the clk after the stop-bit sample clk.
//  - FIFO: first-word-fall-through; pop on rvalid&&rready; pointers wrap mod FIFO_DEPTH.
//  - Simultaneous push and pop when full: both happen, level unchanged, no overrun.
//  - Simultaneous push and pop when empty: pushed byte stored, level=1.
//  - Push when full with no pop: byte dropped, overrun<=1, FIFO contents untouched.
//  - rx_en deasserted mid-frame: current frame completes normally; no new start is detected.
//  - err_clr and a new error in the same clk: the flag ends at 1 (set wins).
//  - baud_div changes take effect at the next counter reload; changing it mid-frame is undefined.
//  - Reset asserted mid-frame: immediate return to reset state and the partial byte is lost.
// CONFIGURATION
//  - UART_RX_PARITY_EN defined: PARITY state is present, parity_err is live,
//    and a mismatched byte is discarded with parity_err<=1.
//  - UART_RX_PARITY_EN undefined: 8N1 framing; DATA goes straight to STOP; parity_err is tied 0.
// TESTING (clk_in 8 MHz, baud_div=4 -> 125000 baud, 64 clk/bit)
//  1. Frame 0x55, 8N1, rready=0
//     -> rvalid=1 one clk after the mid-stop sample; rdata=0x55, fifo_level=1, all error flags 0.
//  2. rx low pulse of 16 clks, then idle -> FSM returns to IDLE; rvalid stays 0, no flags set.
//  3. Data 0xA3 with stop bit driven 0 -> framing_err=1, fifo_level=0.
//     Then err_clr=1 for 1 clk -> framing_err=0.
//  4. 9 back-to-back bytes 0x00..0x08, rready=0 -> fifo_level=8, overrun=1.
//     Then popping gives 0x00..0x07 in order and rvalid=0 afterwards.
//  5. UART_RX_PARITY_EN, PARITY_ODD=0: byte 0x07 with parity bit 0 -> parity_err=1, not stored.
//     Byte 0x07 with parity bit 1 -> rdata=0x07.
//  6. reset=0 for 3 clks during data bit 4, then a clean frame 0x3C
//     -> all outputs 0 during reset; afterwards exactly one byte, 0x3C.

Source files
------------

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 16x oversampling UART receiver with 3-tick majority vote and FWFT receive FIFO.
// Ports: clk_in/reset (async, active-low); rx serial in (idle high); rx_en gates start detection;
//   baud_div = clk_in cycles per oversample tick (0 acts as 1); rdata/rvalid/rready FWFT pop port;
//   fifo_level = bytes held; framing_err/parity_err/overrun sticky, cleared by err_clr (set wins).
// Build option: define UART_RX_PARITY_EN for 8-data + parity framing; otherwise 8N1 and parity_err stays 0.
module uart_rx_sampler #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH = 16,
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          rx,
  input  logic                          rx_en,
  input  logic [DIV_WIDTH-1:0]          baud_div,
  output logic [7:0]                    rdata,
  output logic                          rvalid,
  input  logic                          rready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          framing_err,
  output logic                          parity_err,
  output logic                          overrun,
  input  logic                          err_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] FULL_LVL = FIFO_DEPTH[AW:0];
  localparam logic [3:0] MID = 4'(OVERSAMPLE / 2 - 1);
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_nx;
  logic rx_s1, rx_s2;
  logic [2:0] maj;
  logic [DIV_WIDTH-1:0] div_cnt, reload;
  logic [3:0] os_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic par_bad;
  logic tick, sample, vote, push, do_push, do_pop, full, fe_set, pe_set;
  logic [AW-1:0] wptr, rptr;
  logic [7:0] mem [FIFO_DEPTH];
  assign reload = (baud_div == '0) ? '0 : baud_div - DIV_WIDTH'(1);
  // The divider only runs inside a frame, so every frame starts phase-aligned to its start edge.
  assign tick = state != IDLE && div_cnt == '0;
  assign sample = tick && os_cnt == MID;
  assign vote = (maj[0] & maj[1]) | (maj[0] & maj[2]) | (maj[1] & maj[2]);
  assign pe_set = PAR_EN && state == PARITY && sample && (vote != (^shreg ^ PARITY_ODD));
  assign fe_set = state == STOP && sample && !vote;
  assign push = state == STOP && sample && vote && !par_bad;
  assign full = fifo_level == FULL_LVL;
  assign rvalid = fifo_level != '0;
  assign do_pop = rvalid && rready;
  assign do_push = push && (!full || do_pop);
  assign rdata = rvalid ? mem[rptr] : 8'h00;
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      state <= IDLE;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      state <= state_nx;
    end
  // STOP hands back to IDLE at mid-stop so the next start edge is never missed.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!rx_s2 && rx_en) state_nx = START;
      START:   if (sample) state_nx = vote ? IDLE : DATA;
      DATA:    if (sample && bit_cnt == 3'd7) state_nx = PAR_EN ? PARITY : STOP;
      PARITY:  if (sample) state_nx = STOP;
      STOP:    if (sample) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) begin
      div_cnt <= '0;
      os_cnt <= '0;
      bit_cnt <= '0;
      maj <= 3'b111;
      shreg <= '0;
      par_bad <= 1'b0;
    end else begin
      div_cnt <= (state == IDLE || tick) ? reload : div_cnt - DIV_WIDTH'(1);
      os_cnt <= (state == IDLE) ? '0 : os_cnt + 4'(tick);
      if (tick) maj <= {maj[1:0], rx_s2};
      if (state == IDLE) bit_cnt <= '0;
      if (state == DATA && sample) begin
        shreg <= {vote, shreg[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
      par_bad <= (state == IDLE) ? 1'b0 : (par_bad | pe_set);
    end
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
      fifo_level <= '0;
      framing_err <= 1'b0;
      parity_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      fifo_level <= fifo_level + LW'(do_push) - LW'(do_pop);
      framing_err <= fe_set | (framing_err & ~err_clr);
      parity_err <= pe_set | (parity_err & ~err_clr);
      overrun <= (push && full && !do_pop) | (overrun & ~err_clr);
    end
  always_ff @(posedge clk_in)
    if (do_push) mem[wptr] <= shreg;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: scoreboard bench for uart_rx_sampler with directed and randomized frames.
module tb_uart_rx_sampler;
  localparam bit P_ODD = 1'b0;
  logic clk_in = 1'b0, reset = 1'b0, rx = 1'b1, rx_en = 1'b1, err_clr = 1'b0;
  logic rr = 1'b0, rnd_mode = 1'b0, rr_rand = 1'b0, rready;
  logic [15:0] baud_div = 16'd4;
  logic [7:0] rdata;
  logic rvalid, framing_err, parity_err, overrun;
  logic [3:0] fifo_level;
  int n_chk = 0, n_pass = 0, bit_len = 64, fe_cnt = 0;
  logic [7:0] exp_q [$];
`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif
  assign rready = rr | (rnd_mode & rr_rand);
  uart_rx_sampler #(.FIFO_DEPTH(8), .DIV_WIDTH(16), .OVERSAMPLE(16), .PARITY_ODD(P_ODD)) dut (
    .clk_in(clk_in), .reset(reset), .rx(rx), .rx_en(rx_en), .baud_div(baud_div),
    .rdata(rdata), .rvalid(rvalid), .rready(rready), .fifo_level(fifo_level),
    .framing_err(framing_err), .parity_err(parity_err), .overrun(overrun), .err_clr(err_clr)
  );
  always #5 clk_in = ~clk_in;
  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input logic glitch);
    int g;
    rx = 1'b0;
    cyc(bit_len);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (glitch) begin
        g = $urandom_range(2, bit_len - 4);
        cyc(g);
        rx = ~b[i];
        cyc(2);
        rx = b[i];
        cyc(bit_len - 2 - g);
      end else cyc(bit_len);
    end
`ifdef UART_RX_PARITY_EN
    rx = ^b ^ P_ODD ^ par_flip;
    cyc(bit_len);
`endif
    if (stop_ok) begin
      rx = 1'b1;
      cyc(bit_len);
    end else begin
      rx = 1'b0;
      cyc(bit_len * 5 / 8);
      rx = 1'b1;
      cyc(bit_len);
    end
  endtask
  task automatic drain(input string name, input int budget);
    rr = 1'b1;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cyc(1);
    cyc(2);
    rr = 1'b0;
    chk(name, exp_q.size(), 0);
    chk({name, "_rvalid"}, rvalid, 0);
  endtask
  initial begin
    int c0, bd;
    logic [7:0] b;
    logic ok, gl, exp_ov;
    fork
      forever begin
        logic [7:0] e;
        @(negedge clk_in);
        if (reset && rvalid && rready) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL pop_unexpected: got %02h expected none", rdata);
          end else begin
            e = exp_q.pop_front();
            chk("pop_data", rdata, e);
          end
        end
      end
      forever begin
        @(negedge clk_in);
        if (framing_err) fe_cnt++;
      end
      forever begin
        @(posedge clk_in);
        #1;
        rr_rand = 1'($urandom_range(0, 1));
      end
    join_none
    cyc(3);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_flags", {framing_err, parity_err, overrun}, 0);
    reset = 1'b1;
    cyc(5);
    exp_q.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1, 1'b0);
    join_none
    cyc(595);
    chk("t1_not_early", rvalid, 0);
    cyc(25);
    chk("t1_rvalid", rvalid, 1);
    chk("t1_rdata", rdata, 8'h55);
    chk("t1_level", fifo_level, 1);
    chk("t1_flags", {framing_err, parity_err, overrun}, 0);
    cyc(30);
    drain("t1_pop", 10);
    rx = 1'b0;
    cyc(16);
    rx = 1'b1;
    cyc(150);
    chk("t2_rvalid", rvalid, 0);
    chk("t2_flags", {framing_err, parity_err, overrun}, 0);
    send_frame(8'hA3, 1'b0, 1'b0);
    chk("t3_framing", framing_err, 1);
    chk("t3_level", fifo_level, 0);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("t3_cleared", framing_err, 0);
    c0 = fe_cnt;
    err_clr = 1'b1;
    send_frame(8'h5A, 1'b0, 1'b0);
    chk("set_wins", fe_cnt != c0, 1);
    chk("set_then_clr", framing_err, 0);
    err_clr = 1'b0;
    exp_ov = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (exp_q.size() < 8) exp_q.push_back(8'(i));
      else exp_ov = 1'b1;
      send_frame(8'(i), 1'b1, 1'b0);
    end
    chk("t4_level", fifo_level, 8);
    chk("t4_overrun", overrun, exp_ov);
    chk("t4_head", rdata, 8'h00);
    drain("t4_pop", 30);
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    chk("t6_pre_level", fifo_level, 1);
    chk("t6_pre_overrun", overrun, 1);
    rx = 1'b0;
    cyc(bit_len * 5 - 30);
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rvalid", rvalid, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_rdata", rdata, 0);
    chk("t6_flags", {framing_err, parity_err, overrun}, 0);
    cyc(3);
    rx = 1'b1;
    reset = 1'b1;
    cyc(200);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    cyc(2);
    chk("t6_level_after", fifo_level, 1);
    drain("t6_pop", 10);
`ifdef UART_RX_PARITY_EN
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0);
    par_flip = 1'b0;
    chk("t5_parity_err", parity_err, 1);
    chk("t5_level", fifo_level, 0);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("t5_cleared", parity_err, 0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    drain("t5_pop", 10);
`endif
    rnd_mode = 1'b1;
    for (int n = 0; n < 24; n++) begin
      bd = $urandom_range(0, 5);
      baud_div = 16'(bd);
      bit_len = 16 * ((bd == 0) ? 1 : bd);
      b = 8'($urandom);
      ok = $urandom_range(0, 4) != 0;
      gl = bd >= 3 && $urandom_range(0, 1) == 1;
      if (ok) exp_q.push_back(b);
      send_frame(b, ok, gl);
      chk("rnd_framing", framing_err, !ok);
      chk("rnd_overrun", overrun, 0);
      if (!ok) begin
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
      end
      cyc($urandom_range(0, 3 * bit_len));
    end
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) cyc(1);
    rnd_mode = 1'b0;
    chk("rnd_drain", exp_q.size(), 0);
    chk("parity_tied", parity_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
